// File: rtl/sync_fifo_flags.sv
// Single-clock FIFO, any DEPTH, with count, almost/full/empty flags, sticky over/underflow and flush (FWFT via SYNC_FIFO_FWFT_EN).
// Latency: 1 cycle registered read with rd_valid strobe; 0 cycles when SYNC_FIFO_FWFT_EN is defined.
// Backpressure: writes while full and reads while empty are dropped and set the sticky overflow/underflow flags.
module sync_fifo_flags #(
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 16,
    parameter int AF_THRESH  = DEPTH - 4,
    parameter int AE_THRESH  = 4,
    localparam int CW        = $clog2(DEPTH + 1),
    localparam int AW        = $clog2(DEPTH)
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  clear,
    input  logic                  wr_en,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic                  rd_en,
    output logic [DATA_WIDTH-1:0] rd_data,
    output logic                  rd_valid,
    output logic                  full,
    output logic                  empty,
    output logic                  almost_full,
    output logic                  almost_empty,
    output logic [CW-1:0]         count,
    output logic                  overflow,
    output logic                  underflow
);

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]         wr_ptr;
    logic [AW-1:0]         rd_ptr;
    logic                  wr_acc;
    logic                  rd_acc;

    // Flush wins over any request issued in the same cycle.
    assign wr_acc = wr_en && !full  && !clear;
    assign rd_acc = rd_en && !empty && !clear;

    // Explicit wrap so non-power-of-2 depths work.
    function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
        return (p == AW'(DEPTH - 1)) ? '0 : p + AW'(1);
    endfunction

    always_ff @(posedge clk) begin
        if (wr_acc) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else if (clear) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            if (wr_acc) begin
                wr_ptr <= ptr_inc(wr_ptr);
            end
            if (rd_acc) begin
                rd_ptr <= ptr_inc(rd_ptr);
            end
            case ({wr_acc, rd_acc})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
            if (wr_en && full) begin
                overflow <= 1'b1;
            end
            if (rd_en && empty) begin
                underflow <= 1'b1;
            end
        end
    end

    assign full         = (count == CW'(DEPTH));
    assign empty        = (count == '0);
    assign almost_full  = (count >= CW'(AF_THRESH));
    assign almost_empty = (count <= CW'(AE_THRESH));

`ifdef SYNC_FIFO_FWFT_EN
    // Head word is always on display; rd_en only acknowledges it.
    assign rd_data  = mem[rd_ptr];
    assign rd_valid = !empty;
`else
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rd_data  <= '0;
            rd_valid <= 1'b0;
        end else if (clear) begin
            rd_valid <= 1'b0;
        end else begin
            rd_valid <= rd_acc;
            if (rd_acc) begin
                rd_data <= mem[rd_ptr];
            end
        end
    end
`endif

endmodule

// File: doc/sync_fifo_flags.md
Name: sync_fifo_flags

Overview:
Parametrised single-clock synchronous FIFO, the successor to the basic fifo block.
- Supports arbitrary, including non-power-of-2, depth.
- Adds an occupancy count, programmable almost-full/almost-empty flags, sticky overflow/underflow error flags, a synchronous flush and a read-valid strobe.
- Used as the general buffering primitive between producer/consumer blocks in the datapath.

Parameters:
- DATA_WIDTH, 32: width of each entry in bits (>=1).
- DEPTH, 16: number of entries (>=2, any integer).
- AF_THRESH, DEPTH-4: almost_full asserts when count >= AF_THRESH (1..DEPTH).
- AE_THRESH, 4: almost_empty asserts when count <= AE_THRESH (0..DEPTH-1).

Ports:
- clk, input, 1: clock, rising edge.
- reset_n, input, 1: asynchronous active-low reset.
- clear, input, 1: synchronous flush.
- wr_en, input, 1: write request.
- wr_data, input, DATA_WIDTH: write data.
- rd_en, input, 1: read request.
- rd_data, output, DATA_WIDTH: read data.
- rd_valid, output, 1: rd_data holds a freshly popped word.
- full, output, 1: count == DEPTH.
- empty, output, 1: count == 0.
- almost_full, output, 1: count >= AF_THRESH.
- almost_empty, output, 1: count <= AE_THRESH.
- count, output, $clog2(DEPTH+1): current occupancy.
- overflow, output, 1: sticky, a write was attempted while full.
- underflow, output, 1: sticky, a read was attempted while empty.

Behaviour:
- Reset (reset_n=0, asynchronous): pointers=0, count=0, rd_data=0, rd_valid=0, overflow=0, underflow=0. Hence empty=1, full=0, almost_empty=1, almost_full=0 (when AF_THRESH>0). Memory contents are not reset.
- Write accept = wr_en && !full. Read accept = rd_en && !empty. Both are evaluated on the pre-edge state.
- Full with wr_en and rd_en together: the read is accepted and the write is rejected. overflow sets and count drops by 1.
- Empty with wr_en and rd_en together: the write is accepted and the read is rejected. underflow sets and count becomes 1.
- Simultaneous accepted read and write: count is unchanged and both pointers advance.
- Pointers are binary indices 0..DEPTH-1 and wrap to 0 after DEPTH-1, with an explicit compare rather than relying on power-of-2 overflow.
- count is a registered up/down counter and is never derived from the pointers.
- All flags are decoded from registered count and are stable for the whole cycle.
- Read timing: on an accepted read, rd_data <= mem[rd_ptr] at that edge. rd_valid=1 for exactly the following cycle, then 0 unless another read is accepted. rd_data holds its value when no read is accepted. Latency is 1 cycle.
- Write data is visible to a read no earlier than the edge after the write edge.
- overflow/underflow: set on a rejected request and held until reset or clear.
- clear=1 at an edge: pointers=0, count=0, rd_valid=0, overflow=0, underflow=0.
  - clear overrides wr_en/rd_en in the same cycle: neither is accepted and no error flag is set.
  - rd_data keeps its last value.
- Reset asserted mid-operation: all state returns to reset values immediately. Subsequent writes start at index 0.

Optional Feature:
- Macro: SYNC_FIFO_FWFT_EN
- Defined (first-word-fall-through):
  - rd_data = mem[rd_ptr] combinationally and rd_valid = !empty.
  - rd_en acts as a pop/acknowledge of the displayed word, and the next word (or X when the FIFO becomes empty) appears in the same cycle after the edge.
  - Read latency is 0.
  - Accept rules, count, flags and clear are identical to the non-FWFT build.
- Undefined: the registered 1-cycle-latency read described under Behaviour.

Test Plan:
1. Reset check: hold reset_n=0 for 2 cycles. Require empty=1, almost_empty=1, full=0, almost_full=0, count=0, rd_valid=0, overflow=0, underflow=0, rd_data=0.
2. Basic order (DEPTH=16, AF=12, AE=4): write 0xA5A50000..0xA5A50003, then read 2.
   - rd_valid pulses on the cycle after each accept, with rd_data 0xA5A50000 then 0xA5A50001.
   - count=2, almost_empty=1.
3. Fill and overflow: 16 writes. almost_full rises when count reaches 12 and full=1 after the 16th. A 17th write leaves count=16 and sets overflow=1. Draining 16 reads returns all 16 words in order, after which empty=1 and overflow stays 1.
4. Wrap with non-power-of-2 (DEPTH=5): perform 23 writes interleaved with reads, keeping count between 1 and 4. All words are returned in order and the pointers wrap at 4 to 0 without loss.
5. Simultaneous events:
   - At count=8, wr_en+rd_en leaves count=8.
   - At empty, wr_en+rd_en gives count=1, underflow=1, rd_valid=0.
   - At full, wr_en+rd_en gives count=15, overflow=1.
6. Flush and mid-op reset:
   - With count=6 and overflow=1, clear=1 together with wr_en=1 gives count=0, empty=1, overflow=0, and the write is discarded.
   - With count=3, pulse reset_n=0 between edges. Outputs go to reset values without waiting for a clock edge, and the next write/read returns the new word.
